// File: rtl/m_fetch_x32.sv
// RV32 instruction-fetch stage: PC, loadable instruction memory, IF/ID pipeline
// register and a RUN/HALT FSM that stops on an all-zero (illegal) instruction word.
module m_fetch_x32 #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 6
) (
  input  logic               w_clock,
  input  logic               w_reset,
  input  logic               w_stall,
  input  logic               w_redirect,
  input  logic [31:0]        w_redirect_pc,
  input  logic               w_imem_we,
  input  logic [IMEM_AW-1:0] w_imem_addr,
  input  logic [31:0]        w_imem_wdata,
  output logic [31:0]        r_pc,
  output logic [31:0]        r_id_pc,
  output logic [31:0]        r_id_ir,
  output logic               r_id_valid,
  output logic               r_halted,
  output logic [31:0]        r_fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_ir_q, id_ir_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] imem_q [0:(1<<IMEM_AW)-1];
  logic [31:0] w_inst;

  // Memory is not reset; a write on the same edge as a fetch of that word
  // leaves the fetch with the old contents because the read is combinational.
  always_ff @(posedge w_clock) begin
    if (w_imem_we) imem_q[w_imem_addr] <= w_imem_wdata;
  end

  assign w_inst = imem_q[pc_q[IMEM_AW+1:2]];

  // IF/ID handshake: r_id_valid is "valid", ~w_stall is "ready"; while not
  // ready everything holds. Redirect overrides stall and squashes IF/ID.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_ir_d    = id_ir_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    if (w_redirect) begin
      pc_d       = w_redirect_pc & ~32'd3;
      id_pc_d    = 32'h0;
      id_ir_d    = NOP;
      id_valid_d = 1'b0;
      state_d    = S_RUN;
    end else if (!w_stall) begin
      case (state_q)
        S_RUN: begin
          if (w_inst != 32'h0) begin
            id_ir_d    = w_inst;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            cnt_d      = cnt_q + 32'd1;
          end else begin
            state_d    = S_HALT;
            id_valid_d = 1'b0;
            id_ir_d    = NOP;
          end
        end
        S_HALT:  id_valid_d = 1'b0;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_ir_q    <= NOP;
      id_valid_q <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_ir_q    <= id_ir_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign r_pc          = pc_q;
  assign r_id_pc       = id_pc_q;
  assign r_id_ir       = id_ir_q;
  assign r_id_valid    = id_valid_q;
  assign r_halted      = (state_q == S_HALT);
  assign r_fetch_count = cnt_q;

endmodule

// File: tb/tb_m_fetch_x32.sv
// Bench for m_fetch_x32: table-driven run/stall/redirect vectors plus hand-written
// halt, PC-wrap, async-reset and write/fetch-collision sequences.
module tb_m_fetch_x32;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD0 = 32'h0020_82B3;
  localparam logic [31:0] ADD1 = 32'h0041_8333;
  localparam logic [31:0] ADD2 = 32'h0062_83B3;
  localparam logic [31:0] ADDI = 32'h00A0_0093;

  typedef struct packed {
    logic        chk_idpc;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] ir;
    logic        v;
    logic        h;
    logic [31:0] cnt;
  } exp_rec_t;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    exp_rec_t    exp;
  } vec_t;

  localparam int EW = $bits(exp_rec_t);

  logic        w_clock, w_reset, w_reset2, w_stall, w_redirect, w_imem_we;
  logic [31:0] w_redirect_pc, w_imem_wdata;
  logic [5:0]  w_imem_addr;
  logic [31:0] r_pc, r_id_pc, r_id_ir, r_fetch_count;
  logic        r_id_valid, r_halted;
  logic [31:0] p2_pc, p2_id_pc, p2_id_ir, p2_fetch_count;
  logic        p2_id_valid, p2_halted;

  logic [EW-1:0] exp_q[$];
  vec_t          vec[14];
  int            n_checks = 0;
  int            n_fail   = 0;

  m_fetch_x32 #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
    .w_clock(w_clock), .w_reset(w_reset), .w_stall(w_stall), .w_redirect(w_redirect),
    .w_redirect_pc(w_redirect_pc), .w_imem_we(w_imem_we), .w_imem_addr(w_imem_addr),
    .w_imem_wdata(w_imem_wdata), .r_pc(r_pc), .r_id_pc(r_id_pc), .r_id_ir(r_id_ir),
    .r_id_valid(r_id_valid), .r_halted(r_halted), .r_fetch_count(r_fetch_count)
  );

  m_fetch_x32 #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(6)) dut_wrap (
    .w_clock(w_clock), .w_reset(w_reset2), .w_stall(w_stall), .w_redirect(w_redirect),
    .w_redirect_pc(w_redirect_pc), .w_imem_we(w_imem_we), .w_imem_addr(w_imem_addr),
    .w_imem_wdata(w_imem_wdata), .r_pc(p2_pc), .r_id_pc(p2_id_pc), .r_id_ir(p2_id_ir),
    .r_id_valid(p2_id_valid), .r_halted(p2_halted), .r_fetch_count(p2_fetch_count)
  );

  // clock / reset
  initial w_clock = 1'b0;
  always #5 w_clock = ~w_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_rec_t mk(input logic [31:0] pc, input logic [31:0] id_pc,
                                  input logic [31:0] ir, input logic v, input logic h,
                                  input logic [31:0] cnt);
    exp_rec_t e;
    e.chk_idpc = 1'b1; e.pc = pc; e.id_pc = id_pc; e.ir = ir; e.v = v; e.h = h; e.cnt = cnt;
    return e;
  endfunction

  function automatic vec_t mv(input logic s, input logic r, input logic [31:0] rpc,
                              input exp_rec_t e);
    vec_t x;
    x.stall = s; x.redirect = r; x.rpc = rpc; x.exp = e;
    return x;
  endfunction

  function automatic exp_rec_t act1();
    return mk(r_pc, r_id_pc, r_id_ir, r_id_valid, r_halted, r_fetch_count);
  endfunction

  function automatic exp_rec_t act2();
    return mk(p2_pc, p2_id_pc, p2_id_ir, p2_id_valid, p2_halted, p2_fetch_count);
  endfunction

  // scoreboard
  task automatic cmp(input string name, input string field, input logic [31:0] a,
                     input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s.%s: got %08h expected %08h", name, field, a, e);
    end
  endtask

  task automatic check(input string name, input exp_rec_t a);
    exp_rec_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard queue empty, expected an entry", name);
      return;
    end
    e = exp_rec_t'(exp_q.pop_front());
    cmp(name, "pc", a.pc, e.pc);
    if (e.chk_idpc) cmp(name, "id_pc", a.id_pc, e.id_pc);
    cmp(name, "id_ir", a.ir, e.ir);
    cmp(name, "id_valid", {31'b0, a.v}, {31'b0, e.v});
    cmp(name, "halted", {31'b0, a.h}, {31'b0, e.h});
    cmp(name, "count", a.cnt, e.cnt);
  endtask

  // driver
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    w_stall = s; w_redirect = r; w_redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  task automatic step1(input string name, input exp_rec_t e);
    exp_q.push_back(EW'(e));
    tick();
    check(name, act1());
  endtask

  initial begin
    exp_rec_t eh;
    w_reset = 1'b1; w_reset2 = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    w_imem_we = 1'b0; w_imem_addr = '0; w_imem_wdata = '0;

    vec[0]  = mv(0, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 1));
    vec[1]  = mv(1, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 1));
    vec[2]  = mv(1, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 1));
    vec[3]  = mv(0, 0, 32'h0,        mk(32'h8,        32'h4,        ADD1,         1, 0, 2));
    vec[4]  = mv(0, 0, 32'h0,        mk(32'hC,        32'h8,        ADD2,         1, 0, 3));
    vec[5]  = mv(1, 1, 32'h0000_000B, mk(32'h8,       32'h0,        NOP,          0, 0, 3));
    vec[6]  = mv(0, 0, 32'h0,        mk(32'hC,        32'h8,        ADD2,         1, 0, 4));
    vec[7]  = mv(0, 0, 32'h0,        mk(32'h10,       32'hC,        32'hC0DE0003, 1, 0, 5));
    vec[8]  = mv(0, 1, 32'h2,        mk(32'h0,        32'h0,        NOP,          0, 0, 5));
    vec[9]  = mv(0, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 6));
    vec[10] = mv(1, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 6));
    vec[11] = mv(1, 1, 32'hFFFF_FFFF, mk(32'hFFFF_FFFC, 32'h0,      NOP,          0, 0, 6));
    vec[12] = mv(0, 0, 32'h0,        mk(32'h0,        32'hFFFF_FFFC, 32'hC0DE003F, 1, 0, 7));
    vec[13] = mv(0, 0, 32'h0,        mk(32'h4,        32'h0,        ADD0,         1, 0, 8));

    #1;
    exp_q.push_back(EW'(mk(32'h0, 32'h0, NOP, 0, 0, 0)));
    check("reset", act1());
    exp_q.push_back(EW'(mk(32'hFFFF_FFFC, 32'h0, NOP, 0, 0, 0)));
    check("reset_wrap", act2());

    // program load while both instances are held in reset
    w_imem_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w_imem_addr  = 6'(i);
      w_imem_wdata = (i == 0) ? ADD0 : (i == 1) ? ADD1 : (i == 2) ? ADD2
                                     : (32'hC0DE_0000 | 32'(i));
      tick();
    end
    w_imem_we = 1'b0;
    w_reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vec[i].stall, vec[i].redirect, vec[i].rpc);
      step1($sformatf("vec%0d", i), vec[i].exp);
    end

    // halt on illegal word at PC 12, frozen through stall, cleared by redirect
    w_imem_we = 1'b1; w_imem_addr = 6'd3; w_imem_wdata = 32'h0;
    drive(0, 1, 32'h0);
    step1("halt_redir0", mk(32'h0, 32'h0, NOP, 0, 0, 8));
    w_imem_we = 1'b0;
    drive(0, 0, 32'h0);
    step1("halt_f0", mk(32'h4, 32'h0, ADD0, 1, 0, 9));
    step1("halt_f4", mk(32'h8, 32'h4, ADD1, 1, 0, 10));
    step1("halt_f8", mk(32'hC, 32'h8, ADD2, 1, 0, 11));
    eh = mk(32'hC, 32'h0, NOP, 0, 1, 11);
    eh.chk_idpc = 1'b0;
    step1("halt_enter", eh);
    drive(1, 0, 32'h0);
    step1("halt_stall", eh);
    drive(0, 0, 32'h0);
    step1("halt_hold", eh);
    drive(0, 1, 32'h0);
    step1("halt_exit", mk(32'h0, 32'h0, NOP, 0, 0, 11));
    drive(0, 0, 32'h0);
    step1("halt_refetch", mk(32'h4, 32'h0, ADD0, 1, 0, 12));

    // PC wrap from RESET_PC = FFFFFFFC
    w_reset2 = 1'b0;
    exp_q.push_back(EW'(mk(32'h0, 32'hFFFF_FFFC, 32'hC0DE003F, 1, 0, 1)));
    tick();
    check("wrap_w63", act2());
    exp_q.push_back(EW'(mk(32'h4, 32'h0, ADD0, 1, 0, 2)));
    tick();
    check("wrap_w0", act2());

    // asynchronous reset between edges, then write/fetch collision on word 0
    tick();
    #3;
    w_reset = 1'b1;
    #1;
    exp_q.push_back(EW'(mk(32'h0, 32'h0, NOP, 0, 0, 0)));
    check("async_reset", act1());
    w_reset = 1'b0;
    w_imem_we = 1'b1; w_imem_addr = 6'd0; w_imem_wdata = ADDI;
    step1("collide_old", mk(32'h4, 32'h0, ADD0, 1, 0, 1));
    w_imem_we = 1'b0;
    drive(0, 1, 32'h0);
    step1("collide_redir", mk(32'h0, 32'h0, NOP, 0, 0, 1));
    drive(0, 0, 32'h0);
    step1("collide_new", mk(32'h4, 32'h0, ADDI, 1, 0, 2));

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
